// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared widths, lock states and port id type for mem_arbiter
package mem_arb_pkg;
   localparam int ADDR_W = 8;
   localparam int DATA_W = 8;

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      LOCKED0  = 2'd1,
      LOCKED1  = 2'd2
   } lock_state_t;

   typedef logic port_id_t;
endpackage

// File: rtl/rr_grant2.sv
// rtl/rr_grant2.sv - combinational two-way round-robin chooser with lock override
module rr_grant2 import mem_arb_pkg::*; (
   input  logic        valid0,
   input  logic        valid1,
   input  port_id_t    prio,
   input  lock_state_t lock_state,
   output logic [1:0]  grant
);
   always_comb begin
      grant = 2'b00;
      case (lock_state)
         LOCKED0: grant[0] = valid0;
         LOCKED1: grant[1] = valid1;
         default: begin
            if (valid0 && valid1)
               grant = prio ? 2'b10 : 2'b01;
            else
               grant = {valid1, valid0};
         end
      endcase
   end
endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin memory arbiter with bus lock and 1-cycle read responses
// Optional write protection of the top address range is enabled by defining MEM_WP_EN.
module mem_arbiter #(
   parameter int ADDR_W = mem_arb_pkg::ADDR_W,
   parameter int DATA_W = mem_arb_pkg::DATA_W
`ifdef MEM_WP_EN
   ,
   parameter logic [ADDR_W-1:0] WP_BASE = 8'hC0
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic              req0_we,
   input  logic              req0_lock,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              rsp0_valid,
   output logic [DATA_W-1:0] rsp0_rdata,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic              req1_we,
   input  logic              req1_lock,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              rsp1_valid,
   output logic [DATA_W-1:0] rsp1_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_in,
   output logic              memory_w_en,
   output logic              memory_r_en,
   input  logic [DATA_W-1:0] mem_out,
   output logic              locked,
   output logic              wp_err
);
   import mem_arb_pkg::*;

   lock_state_t lock_state;
   port_id_t    prio;
   logic [1:0]  grant;
   port_id_t    sel;
   logic        xfer;
   logic        sel_we;
   logic        sel_lock;
   logic        wp_hit;

   rr_grant2 u_rr (
      .valid0     (req0_valid),
      .valid1     (req1_valid),
      .prio       (prio),
      .lock_state (lock_state),
      .grant      (grant)
   );

   assign req0_ready = grant[0];
   assign req1_ready = grant[1];
   assign xfer       = |grant;
   assign sel        = grant[1];

   // With no grant sel is 0, so the memory sees port 0's address and data.
   assign mem_addr = sel ? req1_addr  : req0_addr;
   assign mem_in   = sel ? req1_wdata : req0_wdata;
   assign sel_we   = sel ? req1_we    : req0_we;
   assign sel_lock = sel ? req1_lock  : req0_lock;

`ifdef MEM_WP_EN
   assign wp_hit = xfer && sel_we && (mem_addr >= WP_BASE);

   logic wp_err_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         wp_err_q <= 1'b0;
      else
         wp_err_q <= wp_hit;
   end
   assign wp_err = wp_err_q;
`else
   assign wp_hit = 1'b0;
   assign wp_err = 1'b0;
`endif

   assign memory_w_en = xfer && sel_we && !wp_hit;
   assign memory_r_en = xfer && !sel_we;

   // prio holds the port preferred on contention: the one not granted last.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_state <= UNLOCKED;
         locked     <= 1'b0;
         prio       <= 1'b0;
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
      end else begin
         rsp0_valid <= grant[0] && !req0_we;
         rsp1_valid <= grant[1] && !req1_we;
         if (xfer) begin
            prio <= ~sel;
            case (lock_state)
               UNLOCKED: begin
                  if (sel_lock) begin
                     lock_state <= sel ? LOCKED1 : LOCKED0;
                     locked     <= 1'b1;
                  end
               end
               default: begin
                  if (!sel_lock) begin
                     lock_state <= UNLOCKED;
                     locked     <= 1'b0;
                  end
               end
            endcase
         end
      end
   end

   assign rsp0_rdata = rsp0_valid ? mem_out : '0;
   assign rsp1_rdata = rsp1_valid ? mem_out : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized and directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       req0_valid, req0_ready, req0_we, req0_lock;
   logic [7:0] req0_addr, req0_wdata;
   logic       rsp0_valid;
   logic [7:0] rsp0_rdata;
   logic       req1_valid, req1_ready, req1_we, req1_lock;
   logic [7:0] req1_addr, req1_wdata;
   logic       rsp1_valid;
   logic [7:0] rsp1_rdata;
   logic [7:0] mem_addr, mem_in, mem_out;
   logic       memory_w_en, memory_r_en, locked, wp_err;

`ifdef MEM_WP_EN
   localparam bit WP = 1'b1;
`else
   localparam bit WP = 1'b0;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mem_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
      .req0_lock(req0_lock), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
      .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
      .req1_lock(req1_lock), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
      .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
      .mem_addr(mem_addr), .mem_in(mem_in), .memory_w_en(memory_w_en),
      .memory_r_en(memory_r_en), .mem_out(mem_out), .locked(locked), .wp_err(wp_err)
   );

   // Memory: 256x8, registered read; initial content addr+0x10.
   logic [7:0] mem [256];
   logic [7:0] mem_q;
   initial for (int i = 0; i < 256; i++) mem[i] = 8'(i + 16);
   always @(posedge clk) begin
      if (memory_w_en) mem[mem_addr] <= mem_in;
      if (memory_r_en) mem_q <= mem[mem_addr];
   end
   assign mem_out = mem_q;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: owner (0 none, 1 port0, 2 port1), preferred port, shadow memory.
   int         m_owner = 0;
   int         m_pref = 0;
   logic [7:0] shadow [256];
   bit         pend_v [2];
   logic [7:0] pend_d [2];
   bit         wp_pend = 0;
   initial for (int i = 0; i < 256; i++) shadow[i] = 8'(i + 16);

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_rsp0_valid", rsp0_valid, 0);
         chk("rst_rsp1_valid", rsp1_valid, 0);
         chk("rst_locked", locked, 0);
         chk("rst_wp_err", wp_err, 0);
         m_owner = 0; m_pref = 0; wp_pend = 0;
         pend_v[0] = 0; pend_v[1] = 0;
      end else begin
         int g;
         bit v [2];
         bit we, lk, prot;
         logic [7:0] a, d;
         v[0] = req0_valid; v[1] = req1_valid;
         g = -1;
         if (m_owner != 0) begin
            if (v[m_owner-1]) g = m_owner - 1;
         end else if (v[0] && v[1]) g = m_pref;
         else if (v[0]) g = 0;
         else if (v[1]) g = 1;

         chk("req0_ready", req0_ready, g == 0);
         chk("req1_ready", req1_ready, g == 1);
         chk("rsp0_valid", rsp0_valid, pend_v[0]);
         chk("rsp0_rdata", rsp0_rdata, pend_v[0] ? pend_d[0] : 8'h00);
         chk("rsp1_valid", rsp1_valid, pend_v[1]);
         chk("rsp1_rdata", rsp1_rdata, pend_v[1] ? pend_d[1] : 8'h00);
         chk("locked", locked, m_owner != 0);
         chk("wp_err", wp_err, wp_pend);

         pend_v[0] = 0; pend_v[1] = 0; wp_pend = 0;
         if (g >= 0) begin
            a  = (g == 0) ? req0_addr  : req1_addr;
            d  = (g == 0) ? req0_wdata : req1_wdata;
            we = (g == 0) ? req0_we    : req1_we;
            lk = (g == 0) ? req0_lock  : req1_lock;
            prot = WP && we && (a >= 8'hC0);
            chk("mem_addr", mem_addr, a);
            chk("mem_in", mem_in, d);
            chk("memory_w_en", memory_w_en, we && !prot);
            chk("memory_r_en", memory_r_en, !we);
            if (!we) begin
               pend_v[g] = 1;
               pend_d[g] = shadow[a];
            end else if (!prot) shadow[a] = d;
            wp_pend = prot;
            m_pref = 1 - g;
            if (m_owner == 0 && lk) m_owner = g + 1;
            else if (m_owner != 0 && !lk) m_owner = 0;
         end else begin
            chk("idle_w_en", memory_w_en, 0);
            chk("idle_r_en", memory_r_en, 0);
            chk("idle_addr", mem_addr, req0_addr);
         end
      end
   end

   task automatic drv0(input bit v, input bit we, input bit lk, input logic [7:0] a, input logic [7:0] d);
      req0_valid = v; req0_we = we; req0_lock = lk; req0_addr = a; req0_wdata = d;
   endtask
   task automatic drv1(input bit v, input bit we, input bit lk, input logic [7:0] a, input logic [7:0] d);
      req1_valid = v; req1_we = we; req1_lock = lk; req1_addr = a; req1_wdata = d;
   endtask
   task automatic next_cyc();
      @(posedge clk); #1;
   endtask
   task automatic do_reset();
      drv0(0, 0, 0, 0, 0); drv1(0, 0, 0, 0, 0);
      rst_n = 1'b0;
      repeat (2) next_cyc();
      rst_n = 1'b1;
   endtask

   initial begin
      bit r0, r1;
      drv0(0, 0, 0, 0, 0); drv1(0, 0, 0, 0, 0);
      rst_n = 1'b0;
      repeat (3) next_cyc();
      rst_n = 1'b1;

      // Alternating reads, port 0 first after reset.
      drv0(1, 0, 0, 8'h10, 0); drv1(1, 0, 0, 8'h11, 0);
      @(negedge clk); chk("t1_c1_ready0", req0_ready, 1); chk("t1_c1_ready1", req1_ready, 0); next_cyc();
      @(negedge clk); chk("t1_c2_ready1", req1_ready, 1); chk("t1_c2_rdata0", rsp0_rdata, 8'h20); next_cyc();
      @(negedge clk); chk("t1_c3_ready0", req0_ready, 1); chk("t1_c3_rdata1", rsp1_rdata, 8'h21); next_cyc();
      @(negedge clk); chk("t1_c4_ready1", req1_ready, 1); chk("t1_c4_rsp0", rsp0_valid, 1); next_cyc();
      drv0(0, 0, 0, 0, 0); drv1(0, 0, 0, 0, 0); next_cyc();

      // Read after write on port 1.
      drv1(1, 1, 0, 8'h20, 8'hA5);
      @(negedge clk); chk("t2_wr_ready1", req1_ready, 1); next_cyc();
      drv1(1, 0, 0, 8'h20, 0);
      @(negedge clk); chk("t2_rd_ready1", req1_ready, 1); next_cyc();
      drv1(0, 0, 0, 0, 0);
      @(negedge clk); chk("t2_rsp1_valid", rsp1_valid, 1); chk("t2_rsp1_rdata", rsp1_rdata, 8'hA5); next_cyc();

      // Locked read-modify-write by port 0 while port 1 waits.
      drv0(1, 0, 1, 8'h30, 0); drv1(1, 0, 0, 8'h40, 0);
      @(negedge clk); chk("t3_ready0", req0_ready, 1); chk("t3_ready1_a", req1_ready, 0); next_cyc();
      drv0(0, 0, 0, 0, 0);
      @(negedge clk); chk("t3_locked_a", locked, 1); chk("t3_ready1_b", req1_ready, 0);
      chk("t3_rdata0", rsp0_rdata, 8'h40); next_cyc();
      drv0(1, 1, 0, 8'h30, 8'h77);
      @(negedge clk); chk("t3_ready0_w", req0_ready, 1); chk("t3_ready1_c", req1_ready, 0);
      chk("t3_locked_b", locked, 1); next_cyc();
      drv0(0, 0, 0, 0, 0);
      @(negedge clk); chk("t3_ready1_after", req1_ready, 1); chk("t3_unlocked", locked, 0); next_cyc();
      drv1(0, 0, 0, 0, 0); next_cyc();

      // Reset while LOCKED1 with a read in flight.
      drv1(1, 0, 1, 8'h50, 0);
      @(negedge clk); chk("t4_ready1_a", req1_ready, 1); next_cyc();
      drv1(1, 0, 1, 8'h51, 0);
      @(negedge clk); chk("t4_ready1_b", req1_ready, 1); chk("t4_locked", locked, 1);
      #1 rst_n = 1'b0; drv1(0, 0, 0, 0, 0);
      #1 chk("t4_rst_rsp1", rsp1_valid, 0); chk("t4_rst_locked", locked, 0);
      next_cyc();
      @(negedge clk); chk("t4_rsp1_dropped", rsp1_valid, 0);
      next_cyc(); rst_n = 1'b1;
      drv0(1, 0, 0, 8'h60, 0); drv1(1, 0, 0, 8'h61, 0);
      @(negedge clk); chk("t4_ready0_first", req0_ready, 1); chk("t4_ready1_first", req1_ready, 0); next_cyc();
      drv0(0, 0, 0, 0, 0); drv1(0, 0, 0, 0, 0); next_cyc();

      // Write to the protected range.
      drv0(1, 1, 0, 8'hC0, 8'hFF);
      @(negedge clk); chk("t5_ready0", req0_ready, 1); chk("t5_w_en", memory_w_en, !WP); next_cyc();
      drv0(0, 0, 0, 0, 0);
      @(negedge clk); chk("t5_wp_err", wp_err, WP); next_cyc();
      @(negedge clk); chk("t5_wp_err_off", wp_err, 0);
      drv0(1, 0, 0, 8'hC0, 0); next_cyc();
      drv0(0, 0, 0, 0, 0);
      @(negedge clk); chk("t5_rdata", rsp0_rdata, WP ? 8'hD0 : 8'hFF); next_cyc();

      // Port 0 alone for five cycles, then port 1 wins the first contention.
      do_reset();
      drv0(1, 0, 0, 8'h70, 0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); chk("t6_ready0", req0_ready, 1); next_cyc();
      end
      drv1(1, 0, 0, 8'h71, 0);
      @(negedge clk); chk("t6_ready1", req1_ready, 1); chk("t6_ready0_lose", req0_ready, 0); next_cyc();
      drv0(0, 0, 0, 0, 0); drv1(0, 0, 0, 0, 0); next_cyc();

      // Randomized traffic with valid held until accepted.
      r0 = 1; r1 = 1;
      for (int c = 0; c < 1500; c++) begin
         if (!req0_valid || r0)
            drv0($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
                 8'($urandom), 8'($urandom));
         if (!req1_valid || r1)
            drv1($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
                 8'($urandom), 8'($urandom));
         if (c == 700) begin
            rst_n = 1'b0; drv0(0, 0, 0, 0, 0); drv1(0, 0, 0, 0, 0);
         end
         if (c == 702) rst_n = 1'b1;
         @(negedge clk); r0 = req0_ready; r1 = req1_ready;
         next_cyc();
      end
      drv0(0, 0, 0, 0, 0); drv1(0, 0, 0, 0, 0);
      repeat (2) next_cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
